bus_arbiter_2m: RTL



---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_arb_fsm.sv | 75 +++++++
 rtl/bus_arbiter_2m.sv | 85 ++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  // Upper address nibble that maps onto the DMAC register slave (S1).
  localparam logic [3:0] S1_REGION = 4'h0;

  typedef enum logic [1:0] {IDLE, G0, G1, HAND} arb_state_t;
  typedef enum logic [1:0] {RS_NONE, RS_S0, RS_S1} rsel_t;
  typedef enum logic {MST_M0, MST_M1} master_t;

endpackage

// File: rtl/bus_arb_fsm.sv
// Round-robin arbitration FSM with a hold-time cap; owns state, last_served,
// hold_cnt and the registered grants.
module bus_arb_fsm
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_grant,
  output logic m1_grant
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    state_q, state_d;
  master_t       last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          contested;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = (last_q == MST_M1) ? G0 : G1;
        else if (m0_req)      state_d = G0;
        else if (m1_req)      state_d = G1;
      end
      G0: begin
        if (!m0_req)                            state_d = m1_req ? G1 : IDLE;
        else if (m1_req && hold_q == HOLD_LAST) state_d = HAND;
      end
      G1: begin
        if (!m1_req)                            state_d = m0_req ? G0 : IDLE;
        else if (m0_req && hold_q == HOLD_LAST) state_d = HAND;
      end
      HAND: begin
        // The waiting master is the one that was not served last.
        if (last_q == MST_M0) state_d = m1_req ? G1 : IDLE;
        else                  state_d = m0_req ? G0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == G0 && state_q != G0) last_d = MST_M0;
    if (state_d == G1 && state_q != G1) last_d = MST_M1;

    contested = (state_q == G0 && m1_req) || (state_q == G1 && m0_req);
    if (contested && state_d == state_q) hold_d = hold_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= MST_M1;
      hold_q   <= '0;
      m0_grant <= 1'b0;
      m1_grant <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      m0_grant <= (state_d == G0);
      m1_grant <= (state_d == G1);
    end
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master shared-bus arbiter/interconnect: arbitration FSM, owner mux,
// slave address decode and registered read-return select.
module bus_arbiter_2m #(
  parameter int ADDR_W   = bus_pkg::ADDR_W,
  parameter int DATA_W   = bus_pkg::DATA_W,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M1_req,
  input  logic              M0_wr,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic [DATA_W-1:0] M_din,
  output logic [ADDR_W-1:0] S_address,
  output logic              S_wr,
  output logic [DATA_W-1:0] S_din,
  output logic              S0_sel,
  output logic              S1_sel,
  input  logic [DATA_W-1:0] S0_dout,
  input  logic [DATA_W-1:0] S1_dout
);

  bus_pkg::rsel_t rsel_q, rsel_d;
  logic           active;

  bus_arb_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_req   (M0_req),
    .m1_req   (M1_req),
    .m0_grant (M0_grant),
    .m1_grant (M1_grant)
  );

  // Owner mux driven from the registered grants; an idle bus is all zero.
  always_comb begin
    S_address = '0;
    S_wr      = 1'b0;
    S_din     = '0;
    active    = 1'b0;
    if (M0_grant) begin
      S_address = M0_address;
      S_wr      = M0_wr;
      S_din     = M0_dout;
      active    = M0_req;
    end else if (M1_grant) begin
      S_address = M1_address;
      S_wr      = M1_wr;
      S_din     = M1_dout;
      active    = M1_req;
    end
  end

  always_comb begin
    S1_sel = active && (S_address[ADDR_W-1 -: 4] == bus_pkg::S1_REGION);
    S0_sel = active && !S1_sel;
  end

  always_comb begin
    rsel_d = bus_pkg::RS_NONE;
    if (S0_sel && !S_wr)      rsel_d = bus_pkg::RS_S0;
    else if (S1_sel && !S_wr) rsel_d = bus_pkg::RS_S1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rsel_q <= bus_pkg::RS_NONE;
    else          rsel_q <= rsel_d;
  end

  always_comb begin
    unique case (rsel_q)
      bus_pkg::RS_S0: M_din = S0_dout;
      bus_pkg::RS_S1: M_din = S1_dout;
      default:        M_din = '0;
    endcase
  end

endmodule
